fft_peak_detector: RTL

Downstream consumer of the FFT wrapper's output stream. Takes one complex bin per valid cycle (real/imag, sop/eop framed) and computes power re²+im² for each bin. Tracks the strongest bin across the frame and, at frame end, emits one peak record: bin index and power. Gives the NCO→FFT chain a single per-frame tone-frequency estimate and flags malformed frames.

---
 rtl/fft_pkg.sv | 13 +
 rtl/fft_bin_power.sv | 55 +++++
 rtl/fft_peak_detector.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT chain definitions: default sizes, the peak detector FSM states
// and the peak record layout.
package fft_pkg;
  localparam int FFT_LEN_DEF = 1024;
  localparam int FFT_DW      = 25;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} fsm_state_t;

  typedef struct packed {
    logic [$clog2(FFT_LEN_DEF)-1:0] bin;
    logic [2*FFT_DW-1:0]            power;
  } bin_pow_t;
endpackage

// File: rtl/fft_bin_power.sv
// Two-stage power pipeline: S1 squares real/imag, S2 sums them.
// Tags ride alongside the data so the consumer sees bin metadata aligned with power.
module fft_bin_power #(
  parameter int DW    = 25,
  parameter int TAG_W = 1,
  localparam int PW   = 2*DW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] im_i,
  output logic                 valid_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [PW-1:0]        power_o
);
  localparam int SW     = 2*DW-1;
  localparam int STAGES = 2;

  logic signed [SW-1:0]          re_x, im_x, re_sq, im_sq;
  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1][TAG_W-1:0]    tag_pipe;
  logic [SW-1:0]                 re2_q, im2_q;
  logic [PW-1:0]                 pow_q;

  // A square of a DW-bit signed value is at most 2^(2DW-2), so the low SW
  // bits of the product are exact when read as unsigned.
  assign re_x  = SW'(re_i);
  assign im_x  = SW'(im_i);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      re2_q    <= '0;
      im2_q    <= '0;
      pow_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], valid_i};
      tag_pipe <= {tag_pipe[1], tag_i};
      if (valid_i) begin
        re2_q <= re_sq;
        im2_q <= im_sq;
      end
      if (vld_pipe[1]) pow_q <= PW'(re2_q) + PW'(im2_q);
    end
  end

  assign valid_o = vld_pipe[STAGES];
  assign tag_o   = tag_pipe[STAGES];
  assign power_o = pow_q;
endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over an FFT bin stream: frames are checked at the input,
// the running max is tracked at the output of the power pipeline.
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int  DW            = FFT_DW,
  parameter int  FFT_LEN       = FFT_LEN_DEF,
  parameter bit  SKIP_DC       = 1'b1,
  parameter bit  HALF_SPECTRUM = 1'b1,
  localparam int BIN_W         = $clog2(FFT_LEN),
  localparam int PW            = 2*DW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 src_valid,
  input  logic                 src_sop,
  input  logic                 src_eop,
  input  logic signed [DW-1:0] src_real,
  input  logic signed [DW-1:0] src_imag,
  output logic                 peak_valid,
  output logic [BIN_W-1:0]     peak_bin,
  output logic [PW-1:0]        peak_power,
  output logic                 frame_error,
  output logic                 busy
);
  localparam logic [BIN_W-1:0] LAST = BIN_W'(FFT_LEN-1);

  typedef struct packed {
    logic             start;
    logic             search;
    logic             last;
    logic [BIN_W-1:0] bin;
  } tag_t;

  fsm_state_t       state_q, state_d;
  logic [BIN_W-1:0] cnt_q, cnt_d, cur_bin;
  logic             err_q, err_d;
  logic             in_vld;
  tag_t             tag_in, s2_tag;
  logic             s2_vld, s2_last;
  logic [PW-1:0]    s2_pow;

  assign cur_bin = src_sop ? '0 : cnt_q;
  assign s2_last = s2_vld & s2_tag.last;

  // cnt_q holds the index the next non-sop bin will take.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = 1'b0;
    in_vld        = 1'b0;
    tag_in        = '0;
    tag_in.bin    = cur_bin;
    tag_in.search = !(SKIP_DC && cur_bin == '0) && !(HALF_SPECTRUM && cur_bin[BIN_W-1]);
    if (state_q == DONE && s2_last) state_d = IDLE;
    if (src_valid) begin
      if (src_sop && src_eop) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (src_sop) begin
        err_d        = (state_q == ACCUM);
        state_d      = ACCUM;
        cnt_d        = BIN_W'(1);
        in_vld       = 1'b1;
        tag_in.start = 1'b1;
      end else if (state_q == ACCUM) begin
        in_vld = 1'b1;
        if (src_eop) begin
          if (cnt_q == LAST) begin
            state_d     = DONE;
            tag_in.last = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q == LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + BIN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  fft_bin_power #(.DW(DW), .TAG_W($bits(tag_t))) u_pow (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (in_vld),
    .tag_i   (tag_in),
    .re_i    (src_real),
    .im_i    (src_imag),
    .valid_o (s2_vld),
    .tag_o   (s2_tag),
    .power_o (s2_pow)
  );

  logic             have_q, have_d, pv_q;
  logic [PW-1:0]    max_q, max_d, ppow_q;
  logic [BIN_W-1:0] mbin_q, mbin_d, pbin_q;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    have_d = have_q;
    max_d  = max_q;
    mbin_d = mbin_q;
    if (s2_vld) begin
      if (s2_tag.start) begin
        have_d = 1'b0;
        max_d  = '0;
        mbin_d = '0;
      end
      if (s2_tag.search && (!have_d || s2_pow > max_d)) begin
        have_d = 1'b1;
        max_d  = s2_pow;
        mbin_d = s2_tag.bin;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_q <= 1'b0;
      max_q  <= '0;
      mbin_q <= '0;
      pv_q   <= 1'b0;
      pbin_q <= '0;
      ppow_q <= '0;
    end else begin
      have_q <= have_d;
      max_q  <= max_d;
      mbin_q <= mbin_d;
      pv_q   <= s2_last;
      if (s2_last) begin
        pbin_q <= mbin_d;
        ppow_q <= max_d;
      end
    end
  end

  assign peak_valid  = pv_q;
  assign peak_bin    = pbin_q;
  assign peak_power  = ppow_q;
  assign frame_error = err_q;
  assign busy        = (state_q != IDLE);
endmodule
